song_sequencer: RTL and testbench

- Playback-side partner of the menu/button state controller.
- Latches the confirmed song id, then steps through that song's note chart at the song's tempo while the controller is in PLAY.
- Scores player hits against the current note and raises finish so the controller moves PLAY -> FINISH.
- Drives note data to the LED matrix renderer.

---
 rtl/song_sequencer.sv | 133 +++++++++++++
 tb/tb_song_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - plays the confirmed song's note chart at its tempo and scores lane hits
module song_sequencer #(
  parameter int BEAT_CYCLES = 25000,
  parameter int SONG_LEN    = 32,
  localparam int SW         = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    state,
  input  logic [1:0]    song_confirm,
  input  logic [2:0]    hit,
  output logic          finish,
  output logic          playing,
  output logic          beat_tick,
  output logic [2:0]    note_lane,
  output logic [2:0]    next_note,
  output logic [SW-1:0] step_idx,
  output logic [1:0]    song_id,
  output logic [7:0]    score
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = $clog2(BEAT_CYCLES);
  localparam logic [CW-1:0] P1_LAST   = CW'(BEAT_CYCLES - 1);
  localparam logic [CW-1:0] P2_LAST   = CW'(BEAT_CYCLES - BEAT_CYCLES / 4 - 1);
  localparam logic [CW-1:0] P3_LAST   = CW'(BEAT_CYCLES / 2 - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(SONG_LEN - 1);

  logic [1:0]    fsm;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_last;
  logic [2:0]    hit_done;
  logic [2:0]    gain;
  logic [1:0]    gain_sum;
  logic [8:0]    score_sum;
  logic          in_run;

  // Chart ROM: lane mask of step i of song s is (i + s) mod 8, 0 being a rest.
  function automatic logic [2:0] chart(input logic [1:0] s, input logic [SW-1:0] i);
    logic [SW+1:0] t;
    t = {2'b00, i} + {{SW{1'b0}}, s};
    return t[2:0];
  endfunction

  assign in_run    = (fsm == RUN);
  assign playing   = in_run;
  assign finish    = (fsm == DONE);
  assign note_lane = in_run ? chart(song_id, step_idx) : 3'd0;
  assign next_note = (in_run && step_idx != LAST_STEP) ? chart(song_id, step_idx + SW'(1)) : 3'd0;

  always_comb begin
    case (song_id)
      2'd2:    beat_last = P2_LAST;
      2'd3:    beat_last = P3_LAST;
      default: beat_last = P1_LAST;
    endcase
  end

  // Each lane scores at most once per step; up to three lanes can land together.
  assign gain      = hit & note_lane & ~hit_done;
  assign gain_sum  = {1'b0, gain[0]} + {1'b0, gain[1]} + {1'b0, gain[2]};
  assign score_sum = {1'b0, score} + {7'b0, gain_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      beat_cnt  <= '0;
      hit_done  <= 3'd0;
      beat_tick <= 1'b0;
      step_idx  <= '0;
      song_id   <= 2'd0;
      score     <= 8'd0;
    end else begin
      beat_tick <= 1'b0;
      case (fsm)
        IDLE: begin
          if (state == 2'd1 && song_confirm != 2'd0) begin
            song_id <= song_confirm;
            fsm     <= ARMED;
          end
        end
        ARMED: begin
          if (state == 2'd2) begin
            fsm      <= RUN;
            step_idx <= '0;
            beat_cnt <= '0;
            score    <= 8'd0;
            hit_done <= 3'd0;
          end else if (state == 2'd0) begin
            fsm     <= IDLE;
            song_id <= 2'd0;
          end else if (state == 2'd1 && song_confirm != 2'd0) begin
            song_id <= song_confirm;
          end
        end
        RUN: begin
          if (state != 2'd2) begin
            fsm      <= IDLE;
            step_idx <= '0;
            song_id  <= 2'd0;
            beat_cnt <= '0;
            hit_done <= 3'd0;
          end else begin
            score <= score_sum[8] ? 8'hff : score_sum[7:0];
            if (beat_cnt == beat_last) begin
              // Boundary-cycle hits were judged above against the old step.
              beat_tick <= 1'b1;
              beat_cnt  <= '0;
              hit_done  <= 3'd0;
              if (step_idx == LAST_STEP) fsm <= DONE;
              else step_idx <= step_idx + SW'(1);
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
              hit_done <= hit_done | gain;
            end
          end
        end
        default: begin
          if (state != 2'd2) begin
            fsm      <= IDLE;
            song_id  <= 2'd0;
            step_idx <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer
module tb_song_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  logic [1:0] song_confirm;
  logic [2:0] hit;
  logic       finish;
  logic       playing;
  logic       beat_tick;
  logic [2:0] note_lane;
  logic [2:0] next_note;
  logic [1:0] step_idx;
  logic [1:0] song_id;
  logic [7:0] score;

  int compared = 0;
  int mismatched = 0;

  song_sequencer #(.BEAT_CYCLES(8), .SONG_LEN(4)) dut (
    .clk(clk), .rst(rst), .state(state), .song_confirm(song_confirm), .hit(hit),
    .finish(finish), .playing(playing), .beat_tick(beat_tick), .note_lane(note_lane),
    .next_note(next_note), .step_idx(step_idx), .song_id(song_id), .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_song(input logic [1:0] s);
    state = 2'd1;
    song_confirm = s;
    tick;
    chk("armed_song_id", song_id, s);
    song_confirm = 2'd0;
    state = 2'd2;
    tick;
  endtask

  // Called at the first RUN sample; walks every cycle through the finish cycle.
  task automatic run_song(input int s, input int p);
    for (int c = 0; c <= 4 * p; c++) begin
      int st;
      st = (c < 4 * p) ? c / p : 3;
      if (c < 4 * p) begin
        chk("run_note_lane", note_lane, st + s);
        chk("run_next_note", next_note, (st < 3) ? st + s + 1 : 0);
        chk("run_step_idx", step_idx, st);
        chk("run_playing", playing, 1);
        chk("run_finish", finish, 0);
      end else begin
        chk("done_finish", finish, 1);
        chk("done_playing", playing, 0);
        chk("done_note_lane", note_lane, 0);
        chk("done_next_note", next_note, 0);
        chk("done_step_idx", step_idx, 3);
      end
      chk("run_beat_tick", beat_tick, (c > 0 && c % p == 0) ? 1 : 0);
      if (c < 4 * p) tick;
    end
  endtask

  initial begin
    rst = 1'b1;
    state = 2'd0;
    song_confirm = 2'd0;
    hit = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_finish", finish, 0);
    chk("rst_playing", playing, 0);
    chk("rst_beat_tick", beat_tick, 0);
    chk("rst_note_lane", note_lane, 0);
    chk("rst_next_note", next_note, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_song_id", song_id, 0);
    chk("rst_score", score, 0);
    rst = 1'b0;
    tick;

    // Song 1: full playback, finish held in PLAY, dropped on FINISH
    start_song(2'd1);
    run_song(1, 8);
    repeat (3) tick;
    chk("finish_held", finish, 1);
    state = 2'd3;
    tick;
    chk("finish_drop", finish, 0);
    chk("finish_song_id", song_id, 0);
    state = 2'd0;
    tick;

    // Songs 2 and 3 tempos
    start_song(2'd2);
    run_song(2, 6);
    state = 2'd0;
    tick;
    chk("song2_exit_finish", finish, 0);
    start_song(2'd3);
    run_song(3, 4);
    state = 2'd0;
    tick;

    // Scoring on song 1
    start_song(2'd1);
    chk("score_entry", score, 0);
    hit = 3'b001;
    tick;
    chk("score_first_hit", score, 1);
    hit = 3'b001;
    tick;
    chk("score_repeat_hit", score, 1);
    hit = 3'b010;
    tick;
    chk("score_wrong_lane", score, 1);
    hit = 3'b000;
    repeat (13) tick;
    chk("score_step2_mask", note_lane, 3'b011);
    hit = 3'b011;
    tick;
    chk("score_double_hit", score, 3);
    hit = 3'b000;
    repeat (6) tick;
    chk("score_boundary_step", step_idx, 2);
    hit = 3'b100;
    tick;
    chk("score_boundary_hit", score, 3);
    chk("score_new_step", step_idx, 3);
    hit = 3'b100;
    tick;
    chk("score_new_step_hit", score, 4);
    hit = 3'b000;
    state = 2'd0;
    tick;
    chk("score_hold_abort", score, 4);

    // Saturation, then abort mid-song
    start_song(2'd1);
    chk("sat_entry_clear", score, 0);
    force dut.score = 8'd254;
    #1;
    release dut.score;
    hit = 3'b001;
    tick;
    chk("sat_255", score, 255);
    hit = 3'b000;
    repeat (7) tick;
    chk("sat_step1_mask", note_lane, 3'b010);
    hit = 3'b010;
    tick;
    chk("sat_stays", score, 255);
    hit = 3'b000;
    tick;
    state = 2'd0;
    tick;
    chk("abort_playing", playing, 0);
    chk("abort_note_lane", note_lane, 0);
    chk("abort_next_note", next_note, 0);
    chk("abort_song_id", song_id, 0);
    chk("abort_step_idx", step_idx, 0);
    chk("abort_finish", finish, 0);
    chk("abort_score_hold", score, 255);
    state = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("noconfirm_playing", playing, 0);
      chk("noconfirm_finish", finish, 0);
    end

    // Confirm outside MENU is ignored
    state = 2'd0;
    song_confirm = 2'd2;
    tick;
    chk("confirm_ignored", song_id, 0);
    song_confirm = 2'd0;
    state = 2'd2;
    tick;
    chk("confirm_ignored_play", playing, 0);
    state = 2'd0;
    tick;

    // Asynchronous reset during RUN
    start_song(2'd3);
    hit = 3'b001;
    tick;
    hit = 3'b000;
    chk("pre_rst_score", score, 1);
    chk("pre_rst_playing", playing, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_playing", playing, 0);
    chk("arst_note_lane", note_lane, 0);
    chk("arst_next_note", next_note, 0);
    chk("arst_song_id", song_id, 0);
    chk("arst_step_idx", step_idx, 0);
    chk("arst_score", score, 0);
    chk("arst_beat_tick", beat_tick, 0);
    rst = 1'b0;
    tick;
    chk("post_rst_playing", playing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
